// File: rtl/siren_ctrl.sv
// Alarm siren controller: entry delay, timed siren, alarm memory and disarm.
// Optional macro SIREN_STROBE_EN makes the lamp strobe on every tick while sounding.
module siren_ctrl #(
   parameter int ENTRY_DELAY = 10,
   parameter int SIREN_TIME  = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       tick,
   input  logic       disarm,
   output logic       S,
   output logic       L,
   output logic [1:0] st
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      SOUND  = 2'd2,
      MEMORY = 2'd3
   } state_t;

   localparam logic [7:0] ED_CNT = 8'(ENTRY_DELAY);
   localparam logic [7:0] ST_CNT = 8'(SIREN_TIME);

   state_t     state;
   state_t     state_nx;
   logic [7:0] cnt;
   logic [7:0] cnt_nx;
   logic       s_nx;
   logic       l_nx;
`ifdef SIREN_STROBE_EN
   logic       phase;
   logic       phase_nx;
`endif

   // Next-state, counter and next-output decode; outputs are registered from the next state.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      s_nx     = 1'b0;
      l_nx     = 1'b0;
`ifdef SIREN_STROBE_EN
      phase_nx = phase;
`endif
      if (disarm) begin
         state_nx = IDLE;
         cnt_nx   = 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (A) begin
                  if (ED_CNT == 8'd0) begin
                     state_nx = SOUND;
                     cnt_nx   = ST_CNT;
`ifdef SIREN_STROBE_EN
                     phase_nx = 1'b1;
`endif
                  end else begin
                     state_nx = DELAY;
                     cnt_nx   = ED_CNT;
                  end
               end else begin
                  state_nx = IDLE;
               end
            end
            DELAY: begin
               if (tick) begin
                  if (cnt > 8'd1) begin
                     cnt_nx = cnt - 8'd1;
                  end else begin
                     state_nx = SOUND;
                     cnt_nx   = ST_CNT;
`ifdef SIREN_STROBE_EN
                     phase_nx = 1'b1;
`endif
                  end
               end else begin
                  cnt_nx = cnt;
               end
            end
            SOUND: begin
               if (tick) begin
                  if (cnt > 8'd1) begin
                     cnt_nx = cnt - 8'd1;
`ifdef SIREN_STROBE_EN
                     phase_nx = ~phase;
`endif
                  end else begin
                     state_nx = MEMORY;
                     cnt_nx   = 8'd0;
                  end
               end else begin
                  cnt_nx = cnt;
               end
            end
            MEMORY: begin
               // Retrigger from memory skips the entry delay.
               if (A) begin
                  state_nx = SOUND;
                  cnt_nx   = ST_CNT;
`ifdef SIREN_STROBE_EN
                  phase_nx = 1'b1;
`endif
               end else begin
                  state_nx = MEMORY;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end
         endcase
      end

      case (state_nx)
         IDLE:   begin s_nx = 1'b0; l_nx = 1'b0; end
         DELAY:  begin s_nx = 1'b0; l_nx = 1'b1; end
         SOUND: begin
            s_nx = 1'b1;
`ifdef SIREN_STROBE_EN
            l_nx = phase_nx;
`else
            l_nx = 1'b1;
`endif
         end
         MEMORY: begin s_nx = 1'b0; l_nx = 1'b1; end
         default: begin s_nx = 1'b0; l_nx = 1'b0; end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 8'd0;
         S     <= 1'b0;
         L     <= 1'b0;
         st    <= 2'd0;
`ifdef SIREN_STROBE_EN
         phase <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         S     <= s_nx;
         L     <= l_nx;
         st    <= state_nx;
`ifdef SIREN_STROBE_EN
         phase <= phase_nx;
`endif
      end
   end

endmodule
